// File: rtl/tdm_demux_1_to_4.sv
// Receive-side TDM demultiplexer: tracks the slot position of a framed sample
// stream and presents each complete four-sample frame on four parallel outputs.
module tdm_demux_1_to_4 #(
    parameter int WIDTH = 1
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [WIDTH-1:0] In,
    input  logic             Valid,
    input  logic             Sync,
    output logic [WIDTH-1:0] Out0,
    output logic [WIDTH-1:0] Out1,
    output logic [WIDTH-1:0] Out2,
    output logic [WIDTH-1:0] Out3,
    output logic [1:0]       Sel,
    output logic             FrameValid,
    output logic             SyncErr,
    output logic             Locked
);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic             frame_valid_q, frame_valid_d;
    logic             sync_err_q, sync_err_d;
    // Slot 3 never needs a shadow: it is forwarded straight to the output.
    logic [WIDTH-1:0] shadow_q [3];
    logic [WIDTH-1:0] shadow_d [3];
    logic [WIDTH-1:0] out_q [4];
    logic [WIDTH-1:0] out_d [4];

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // through this block leaves a value unassigned and no latch is inferred.
        state_d       = state_q;
        sel_d         = sel_q;
        shadow_d      = shadow_q;
        out_d         = out_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;

        if (Valid) begin
            unique case (state_q)
                UNLOCKED: begin
                    if (Sync) begin
                        shadow_d[0] = In;
                        sel_d       = 2'd1;
                        state_d     = LOCKED;
                    end
                end
                LOCKED: begin
                    if (Sync && sel_q != 2'd0) begin
                        // Early sync restarts the frame from this sample.
                        sync_err_d  = 1'b1;
                        shadow_d[0] = In;
                        sel_d       = 2'd1;
                    end else if (!Sync && sel_q == 2'd0) begin
                        sync_err_d = 1'b1;
                        state_d    = UNLOCKED;
                    end else if (sel_q == 2'd3) begin
                        out_d[0]      = shadow_q[0];
                        out_d[1]      = shadow_q[1];
                        out_d[2]      = shadow_q[2];
                        out_d[3]      = In;
                        frame_valid_d = 1'b1;
                        sel_d         = 2'd0;
                    end else begin
                        shadow_d[sel_q] = In;
                        sel_d           = sel_q + 2'd1;
                    end
                end
                default: state_d = UNLOCKED;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value regardless of statement order. The small
    // shadow array is reset like any other register because stale samples
    // must not survive a reset.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q       <= UNLOCKED;
            sel_q         <= 2'd0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            for (int i = 0; i < 3; i++) shadow_q[i] <= '0;
            for (int i = 0; i < 4; i++) out_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
            shadow_q      <= shadow_d;
            out_q         <= out_d;
        end
    end

    assign Out0       = out_q[0];
    assign Out1       = out_q[1];
    assign Out2       = out_q[2];
    assign Out3       = out_q[3];
    assign Sel        = sel_q;
    assign FrameValid = frame_valid_q;
    assign SyncErr    = sync_err_q;
    assign Locked     = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux_1_to_4.sv
// Self-checking bench for tdm_demux_1_to_4: expected frames are queued as the
// last slot is driven and compared whenever FrameValid is observed.
module tb_tdm_demux_1_to_4;

    localparam int W = 4;

    logic         Clk = 1'b0;
    logic         Rst_n;
    logic [W-1:0] In;
    logic         Valid;
    logic         Sync;
    logic [W-1:0] Out0, Out1, Out2, Out3;
    logic [1:0]   Sel;
    logic         FrameValid;
    logic         SyncErr;
    logic         Locked;

    int tests_run = 0;
    int tests_failed = 0;
    int frames_pushed = 0;
    int frames_seen = 0;
    logic [4*W-1:0] exp_q [$];

    tdm_demux_1_to_4 #(.WIDTH(W)) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .In         (In),
        .Valid      (Valid),
        .Sync       (Sync),
        .Out0       (Out0),
        .Out1       (Out1),
        .Out2       (Out2),
        .Out3       (Out3),
        .Sel        (Sel),
        .FrameValid (FrameValid),
        .SyncErr    (SyncErr),
        .Locked     (Locked)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {16'h0, Out0, Out1, Out2, Out3};
    endfunction

    // Present one cycle of stimulus, then sample 1 time unit after the edge.
    task automatic drive(input logic v, input logic s, input logic [W-1:0] d);
        Valid = v;
        Sync  = s;
        In    = d;
        @(posedge Clk);
        #1;
    endtask

    task automatic push_frame(input logic [W-1:0] a, b, c, d);
        exp_q.push_back({a, b, c, d});
        frames_pushed++;
    endtask

    // Scoreboard side: every FrameValid pulse must match the oldest queued frame.
    always @(negedge Clk) begin
        if (Rst_n && (FrameValid || SyncErr)) begin
            check("fv_syncerr_exclusive", {31'h0, FrameValid & SyncErr}, 32'h0);
        end
        if (Rst_n && FrameValid) begin
            frames_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_frame", outs(), 32'hFFFF_FFFF);
            end else begin
                check("frame_outputs", outs(), {16'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        Rst_n = 1'b0;
        Valid = 1'b0;
        Sync  = 1'b0;
        In    = '0;

        // Reset held with random input activity.
        for (int i = 0; i < 4; i++) begin
            drive(1'($urandom), 1'($urandom), W'($urandom));
            check("reset_outs", outs(), 32'h0);
            check("reset_ctl", {27'h0, Sel, FrameValid, SyncErr, Locked}, 32'h0);
        end
        Rst_n = 1'b1;

        // Clean frame 1,0,1,1.
        drive(1'b1, 1'b1, 4'h1);
        check("clean_s0_sel_lock", {29'h0, Sel, Locked}, {29'h0, 2'd1, 1'b1});
        drive(1'b1, 1'b0, 4'h0);
        check("clean_s1_sel", {30'h0, Sel}, 32'd2);
        drive(1'b1, 1'b0, 4'h1);
        check("clean_s2_sel", {30'h0, Sel}, 32'd3);
        check("clean_no_fv_early", {31'h0, FrameValid}, 32'h0);
        push_frame(4'h1, 4'h0, 4'h1, 4'h1);
        drive(1'b1, 1'b0, 4'h1);
        check("clean_fv", {31'h0, FrameValid}, 32'h1);
        check("clean_sel_lock", {29'h0, Sel, Locked}, {29'h0, 2'd0, 1'b1});
        drive(1'b0, 1'b0, 4'h0);
        check("clean_fv_one_cycle", {31'h0, FrameValid}, 32'h0);

        // Stall of 3 cycles between slots 1 and 2; Sync ignored while idle.
        drive(1'b1, 1'b1, 4'h1);
        drive(1'b1, 1'b0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, W'($urandom));
            check("stall_sel_hold", {30'h0, Sel}, 32'd2);
            check("stall_pulses", {30'h0, FrameValid, SyncErr}, 32'h0);
        end
        drive(1'b1, 1'b0, 4'h1);
        check("stall_s2_sel", {30'h0, Sel}, 32'd3);
        push_frame(4'h1, 4'h0, 4'h1, 4'h1);
        drive(1'b1, 1'b0, 4'h1);
        check("stall_fv", {31'h0, FrameValid}, 32'h1);

        // Early sync at Sel == 2.
        drive(1'b1, 1'b1, 4'h3);
        drive(1'b1, 1'b0, 4'h4);
        drive(1'b1, 1'b1, 4'h7);
        check("early_syncerr", {31'h0, SyncErr}, 32'h1);
        check("early_sel_lock", {29'h0, Sel, Locked}, {29'h0, 2'd1, 1'b1});
        check("early_outs_hold", outs(), 32'h1011);
        drive(1'b1, 1'b0, 4'h8);
        check("early_err_one_cycle", {31'h0, SyncErr}, 32'h0);
        drive(1'b1, 1'b0, 4'h9);
        push_frame(4'h7, 4'h8, 4'h9, 4'hA);
        drive(1'b1, 1'b0, 4'hA);
        check("early_refill_fv", {31'h0, FrameValid}, 32'h1);

        // Missing sync, then ignored samples, then relock.
        drive(1'b1, 1'b0, 4'h5);
        check("miss_syncerr", {31'h0, SyncErr}, 32'h1);
        check("miss_sel_lock", {29'h0, Sel, Locked}, 32'h0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 4'h6);
            check("unlocked_ignore", {29'h0, Sel, Locked, SyncErr}, 32'h0);
            check("unlocked_outs_hold", outs(), 32'h789A);
        end
        drive(1'b1, 1'b1, 4'hB);
        check("relock", {29'h0, Sel, Locked}, {29'h0, 2'd1, 1'b1});

        // Asynchronous reset mid-frame, between clock edges.
        drive(1'b1, 1'b0, 4'hC);
        #2;
        Rst_n = 1'b0;
        #1;
        check("async_reset_outs", outs(), 32'h0);
        check("async_reset_ctl", {27'h0, Sel, FrameValid, SyncErr, Locked}, 32'h0);
        #2;
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;
        drive(1'b1, 1'b0, 4'h1);
        check("post_reset_needs_sync", {29'h0, Sel, Locked}, 32'h0);
        drive(1'b1, 1'b1, 4'hA);
        drive(1'b1, 1'b0, 4'h5);
        drive(1'b1, 1'b0, 4'hF);
        push_frame(4'hA, 4'h5, 4'hF, 4'h0);
        drive(1'b1, 1'b0, 4'h0);
        check("post_reset_fv", {31'h0, FrameValid}, 32'h1);

        // Back-to-back frames: FrameValid on every 4th cycle, no dead cycle.
        for (int f = 0; f < 2; f++) begin
            for (int s = 0; s < 4; s++) begin
                if (s == 3) push_frame(4'(f), 4'(f + 3), 4'(f + 6), 4'(f + 9));
                drive(1'b1, s == 0, 4'(f + 3 * s));
                check("b2b_fv_cadence", {31'h0, FrameValid}, {31'h0, s == 3});
            end
        end
        drive(1'b0, 1'b0, 4'h0);
        drive(1'b0, 1'b0, 4'h0);

        check("scoreboard_empty", exp_q.size(), 32'h0);
        check("frames_seen", frames_seen, frames_pushed);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/tdm_demux_1_to_4.md
# tdm_demux_1_to_4

Receive-side counterpart to the 4-to-1 channel multiplexer: takes a time-division-multiplexed sample stream (one channel per slot, slot 0 flagged by `Sync`) and distributes the samples back onto four parallel channel outputs. It sits at the far end of the TDM link in the lab datapath. It tracks the slot position with a counter and collects one frame in shadow registers. All four outputs update together only after a complete, correctly framed set of four samples has arrived.

## Interface
- `WIDTH`, default 1: bit width of one channel sample.

- `Clk`  in  1  system clock; all state changes on rising edge.
- `Rst_n`  in  1  asynchronous, active-low reset.
- `In`  in  WIDTH  serial sample for the current slot.
- `Valid`  in  1  `In` carries a sample this cycle; when low, nothing is consumed and the slot does not advance.
- `Sync`  in  1  qualified by `Valid`; marks the sample as slot 0 of a frame.
- `Out0`..`Out3`  out  WIDTH each  last complete frame, channels 0-3.
- `Sel`  out  2  slot index the next valid sample is written to (mirrors the transmitter's select).
- `FrameValid`  out  1  one-cycle pulse: `Out0`..`Out3` updated this cycle.
- `SyncErr`  out  1  one-cycle pulse: framing violation detected.
- `Locked`  out  1  receiver aligned to frame boundaries.

## Operation
- States: UNLOCKED, LOCKED. `Locked` = (state == LOCKED).
- UNLOCKED:
  - `Valid` && !`Sync`: sample discarded, `Sel` stays 0, no `SyncErr`.
  - `Valid` && `Sync`: sample written to shadow slot 0, `Sel` becomes 1, go to LOCKED.
- LOCKED, `Valid` high:
  - Normal: `Sync` == (`Sel` == 0). Sample goes to shadow[`Sel`]. `Sel` increments modulo 4 (3 wraps to 0).
  - Frame completion: when the sample lands in slot 3, `Out0`..`Out2` load from shadow 0-2 and `Out3` loads `In` directly, all on the same edge. `FrameValid` pulses on that edge.
  - Early sync (`Sync` high, `Sel` != 0): `SyncErr` pulses. The partial frame is discarded and `Out*` are unchanged. The sample is treated as slot 0 (shadow 0 written, `Sel` = 1). Stay LOCKED.
  - Missing sync (`Sync` low, `Sel` == 0): `SyncErr` pulses. The sample is discarded, `Sel` stays 0, go to UNLOCKED.
- `Valid` low: all state holds. `Sync` is ignored. `FrameValid` and `SyncErr` are 0.
- `Out*` change only on frame completion. They hold their values indefinitely between frames and across loss of lock.
- No arithmetic beyond the 2-bit slot counter. Samples pass through unmodified, full WIDTH.

## Timing
- Reset (asynchronous assert, any time): `Out0`..`Out3` = 0, `Sel` = 0, `FrameValid` = 0, `SyncErr` = 0, `Locked` = 0, shadow registers = 0, state UNLOCKED.
- Release of `Rst_n` is synchronous to `Clk`. The first edge after deassertion may consume a sample.
- Reset mid-frame: the partial frame is lost and `Out*` clear to 0. A new `Sync` is required to relock.
- Latency: the slot-3 sample appears on `Out3` one edge after it is presented. `FrameValid` is high for exactly the cycle following that edge.
- Minimum frame period is 4 cycles (`Valid` held high). Back-to-back frames produce a `FrameValid` pulse every 4th cycle with no dead cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.
- `SyncErr` and `FrameValid` are never high in the same cycle.

## Test plan
- Reset values: hold `Rst_n` = 0 with random `In`/`Valid`/`Sync` -> all outputs 0, `Locked` = 0. Assert `Rst_n` low asynchronously between clock edges -> outputs clear immediately.
- Clean frame, WIDTH = 1: `Valid` = 1; slots {`Sync`=1,`In`=1}, {0,0}, {0,1}, {0,1} -> after the 4th edge `Out0..3` = 1,0,1,1, one-cycle `FrameValid`, `Sel` = 0, `Locked` = 1.
- Stalls: same frame with `Valid` = 0 for 3 cycles between slots 1 and 2 -> `Sel` holds at 2 during the stall. The frame completes with identical outputs, and `FrameValid` comes 3 cycles later.
- Early sync: slots 0, 1 sent, then `Sync` = 1 at `Sel` = 2 -> `SyncErr` pulse, `Out*` unchanged, `Sel` = 1. The following 3 samples complete a frame built from the new slot 0.
- Missing sync: after a complete frame, `Valid` = 1, `Sync` = 0 -> `SyncErr` pulse, `Locked` = 0. Further samples without `Sync` are ignored with no `SyncErr`. Next `Sync` relocks with `Sel` = 1.
- Reset mid-frame with WIDTH = 4: after 2 of 4 samples, pulse `Rst_n` -> `Out*` = 0, `Locked` = 0. A subsequent full frame 4'hA, 4'h5, 4'hF, 4'h0 gives `Out0..3` = A, 5, F, 0.
